// File: rtl/sync_fifo_level.sv
// Synchronous valid/ready FIFO with occupancy count, programmable almost-full/almost-empty
// flags, high-water mark, synchronous flush and synchronous active-low reset.
//
// Occupancy state, implied by count (no separate state register):
//   state | meaning
//   EMPTY | count == 0, rd_valid low
//   ONE   | count == 1, head may come from the bypass register
//   MANY  | 2 <= count <= N-1, head always comes from memory
//   FULL  | count == N, wr_ready low
module sync_fifo_level #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  input  logic [DEPTH:0]   af_level,
  input  logic [DEPTH:0]   ae_level,
  output logic [DEPTH:0]   count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [DEPTH:0]   high_water
);

  localparam logic [DEPTH:0] N_ENT   = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] ONE_ENT = {{DEPTH{1'b0}}, 1'b1};
  localparam logic [DEPTH:0] ZERO    = '0;

  logic [WIDTH-1:0] mem [2**DEPTH];
  logic [WIDTH-1:0] mem_q;
  logic [WIDTH-1:0] byp_q;
  logic             byp_sel;

  logic [DEPTH:0]   rd_ptr, wr_ptr;
  logic [DEPTH:0]   rd_ptr_next, wr_ptr_next;
  logic [DEPTH:0]   count_next;
  logic [DEPTH:0]   hw_next;
  logic             do_wr, do_rd;
  logic             load_byp;

  always_comb begin
    do_wr       = wr_valid & wr_ready;
    do_rd       = rd_valid & rd_ready;
    count_next  = count + {{DEPTH{1'b0}}, do_wr} - {{DEPTH{1'b0}}, do_rd};
    wr_ptr_next = wr_ptr + {{DEPTH{1'b0}}, do_wr};
    rd_ptr_next = rd_ptr + {{DEPTH{1'b0}}, do_rd};
    // A write that becomes the sole entry lands at the head before memory can be read back.
    load_byp    = do_wr && (count_next == ONE_ENT);
    hw_next     = (count_next > high_water) ? count_next : high_water;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      wr_ready     <= 1'b0;
      rd_valid     <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      high_water   <= '0;
      byp_sel      <= 1'b0;
    end else if (flush) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      wr_ready     <= 1'b1;
      rd_valid     <= 1'b0;
      almost_full  <= (af_level == ZERO);
      almost_empty <= 1'b1;
      high_water   <= '0;
      byp_sel      <= 1'b0;
    end else begin
      rd_ptr       <= rd_ptr_next;
      wr_ptr       <= wr_ptr_next;
      count        <= count_next;
      wr_ready     <= (count_next != N_ENT);
      rd_valid     <= (count_next != ZERO);
      almost_full  <= (count_next >= af_level);
      almost_empty <= (count_next <= ae_level);
      high_water   <= hw_next;
      byp_sel      <= load_byp;
    end
  end

  // Storage and head registers carry no reset; rd_data is don't-care while rd_valid is low.
  always_ff @(posedge clk) begin
    if (do_wr && !flush)
      mem[wr_ptr[DEPTH-1:0]] <= wr_data;
    mem_q <= mem[rd_ptr_next[DEPTH-1:0]];
    if (load_byp)
      byp_q <= wr_data;
  end

  assign rd_data = byp_sel ? byp_q : mem_q;

endmodule

// File: tb/tb_sync_fifo_level.sv
// Directed and random-soak bench for sync_fifo_level at WIDTH=8, DEPTH=2 (4 entries).
module tb_sync_fifo_level;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] af_level;
  logic [2:0] ae_level;
  logic [2:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] high_water;

  int vectors;
  int miscompares;

  logic [7:0] q[$];
  int         hw_m;
  logic       exp_af, exp_ae;
  logic       m_wr, m_rd;

  sync_fifo_level #(.WIDTH(8), .DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .af_level     (af_level),
    .ae_level     (ae_level),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .high_water   (high_water)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk         = 1'b0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    wr_data     = 8'h99;
    wr_valid    = 1'b1;
    rd_ready    = 1'b0;
    af_level    = 3'd4;
    ae_level    = 3'd0;

    // Reset held three cycles with a pending write
    tick(); tick(); tick();
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_almost_full", almost_full, 0);
    check("rst_high_water", high_water, 0);
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    tick();
    check("rel_wr_ready", wr_ready, 1);
    check("rel_count", count, 0);

    // Fill to FULL, then a held fifth write
    for (int i = 0; i < 4; i++) begin
      wr_data  = 8'(17 * (i + 1));
      wr_valid = 1'b1;
      tick();
      check("fill_count", count, i + 1);
    end
    check("full_wr_ready", wr_ready, 0);
    check("full_almost_full", almost_full, 1);
    check("full_almost_empty", almost_empty, 0);
    check("full_high_water", high_water, 4);
    wr_data = 8'h55;
    tick();
    check("held_count", count, 4);
    check("held_wr_ready", wr_ready, 0);
    check("head_11", rd_data, 8'h11);

    // Drain; 0x55 enters right after the first read
    rd_ready = 1'b1;
    tick();
    check("drain_count3", count, 3);
    check("drain_wr_ready", wr_ready, 1);
    check("head_22", rd_data, 8'h22);
    tick();
    wr_valid = 1'b0;
    check("drain_count3b", count, 3);
    check("head_33", rd_data, 8'h33);
    tick();
    check("head_44", rd_data, 8'h44);
    tick();
    check("head_55", rd_data, 8'h55);
    check("drain_count1", count, 1);
    tick();
    check("drained_rd_valid", rd_valid, 0);
    check("drained_count", count, 0);
    rd_ready = 1'b0;

    // Bypass from EMPTY, then sustained write/read at count 1
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    tick();
    check("byp_rd_valid", rd_valid, 1);
    check("byp_rd_data", rd_data, 8'hA5);
    check("byp_count", count, 1);
    rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_data = 8'(i);
      check("stream_rd_valid", rd_valid, 1);
      check("stream_rd_data", rd_data, (i == 1) ? 8'hA5 : 8'(i - 1));
      tick();
      check("stream_count", count, 1);
    end
    wr_valid = 1'b0;
    check("stream_last", rd_data, 8'h10);
    tick();
    check("stream_end_valid", rd_valid, 0);
    check("stream_end_count", count, 0);
    rd_ready = 1'b0;

    // Flags with af_level=3, ae_level=1 after a flush clears the high-water mark
    af_level = 3'd3;
    ae_level = 3'd1;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    check("fl0_high_water", high_water, 0);
    check("fl0_almost_empty", almost_empty, 1);
    check("fl0_almost_full", almost_full, 0);
    for (int i = 0; i < 3; i++) begin
      wr_data  = 8'(8'h31 + i);
      wr_valid = 1'b1;
      tick();
      check("flg_count", count, i + 1);
      check("flg_almost_full", almost_full, (i == 2));
      check("flg_almost_empty", almost_empty, (i == 0));
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    tick();
    check("flg_rd_count2", count, 2);
    check("flg_rd_af", almost_full, 0);
    check("flg_rd_ae", almost_empty, 0);
    tick();
    check("flg_rd_count1", count, 1);
    check("flg_rd_ae1", almost_empty, 1);
    check("flg_rd_af1", almost_full, 0);
    check("flg_high_water", high_water, 3);
    rd_ready = 1'b0;

    // Flush at count 3 with a concurrent write of 0x77
    wr_valid = 1'b1;
    wr_data  = 8'h34;
    tick();
    wr_data = 8'h35;
    tick();
    check("pre_flush_count", count, 3);
    wr_data = 8'h77;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_rd_valid", rd_valid, 0);
    check("flush_high_water", high_water, 0);
    check("flush_wr_ready", wr_ready, 1);
    check("flush_almost_empty", almost_empty, 1);
    check("flush_almost_full", almost_full, 0);
    wr_data  = 8'h88;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("post_flush_data", rd_data, 8'h88);
    check("post_flush_count", count, 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("post_flush_empty", rd_valid, 0);

    // Threshold extremes: af_level=0 and ae_level=N keep both flags high
    af_level = 3'd0;
    ae_level = 3'd4;
    tick();
    check("af0_empty", almost_full, 1);
    wr_valid = 1'b1;
    tick(); tick(); tick(); tick();
    wr_valid = 1'b0;
    check("ext_count", count, 4);
    check("ext_almost_full", almost_full, 1);
    check("ext_almost_empty", almost_empty, 1);

    // Reset in the middle of a transfer
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    rst_n    = 1'b0;
    tick();
    check("midrst_wr_ready", wr_ready, 0);
    check("midrst_count", count, 0);
    check("midrst_rd_valid", rd_valid, 0);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("midrst_rel_wr_ready", wr_ready, 1);

    // Random soak against a queue model
    af_level = 3'd3;
    ae_level = 3'd1;
    flush    = 1'b1;
    tick();
    flush  = 1'b0;
    hw_m   = 0;
    exp_af = 1'b0;
    exp_ae = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      check("soak_count", count, q.size());
      check("soak_wr_ready", wr_ready, (q.size() != 4));
      check("soak_rd_valid", rd_valid, (q.size() != 0));
      check("soak_almost_full", almost_full, exp_af);
      check("soak_almost_empty", almost_empty, exp_ae);
      check("soak_high_water", high_water, hw_m);
      if (q.size() != 0)
        check("soak_rd_data", rd_data, q[0]);
      if (c % 256 == 0) begin
        af_level = 3'($urandom_range(0, 4));
        ae_level = 3'($urandom_range(0, 4));
      end
      wr_valid = 1'($urandom_range(0, 1));
      rd_ready = 1'($urandom_range(0, 1));
      wr_data  = 8'($urandom);
      m_wr = wr_valid && (q.size() != 4);
      m_rd = rd_ready && (q.size() != 0);
      if (m_rd) void'(q.pop_front());
      if (m_wr) q.push_back(wr_data);
      if (q.size() > hw_m) hw_m = q.size();
      exp_af = (q.size() >= int'(af_level));
      exp_ae = (q.size() <= int'(ae_level));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
